// File: rtl/display_pkg.sv
// Shared types and constants for the count display driver: conversion states,
// segment patterns and digit slot indices.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } conv_state_t;

  // Active-high gfedcba patterns for decimal digits 0..9
  localparam logic [6:0] SEG_PATTERN [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [1:0] UNITS    = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;

  // Non-decimal nibbles never reach here in practice; they render as all-off.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_PATTERN[d] : 7'h00;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per
// clock). busy covers SHIFT and LOAD; done marks the cycle the result is final.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state_reg, state_next;
  logic [19:0] shift_reg, shift_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [19:0] adjusted;

  assign adjusted[7:0] = shift_reg[7:0];

  for (genvar gi = 0; gi < 3; gi++) begin : g_adjust
    logic [3:0] nib;
    assign nib = shift_reg[8 + 4*gi +: 4];
    assign adjusted[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next   = {12'b0, bin};
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        shift_next   = adjusted << 1;
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = LOAD;
      end
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == LOAD);
  assign bcd  = shift_reg[19:8];

endmodule

// File: rtl/count_display_driver.sv
// Shows an 8-bit count as decimal 0..255 on a 3-digit multiplexed 7-segment
// display; re-converts whenever the captured value differs from the last one.
module count_display_driver
  import display_pkg::*;
#(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] digit_en,
  output logic       busy
);

  localparam int SCAN_DIV = CLK_FREQ / SCAN_HZ;
  localparam int PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  logic [7:0]       value_reg, last_conv_reg;
  logic [11:0]      disp_reg;
  logic [PRE_W-1:0] prescale_reg;
  logic [1:0]       scan_idx_reg;
  logic [6:0]       seg_reg, seg_next;
  logic [2:0]       dig_reg, dig_next;
  logic             conv_start, conv_busy, conv_done;
  logic [11:0]      conv_bcd;

  // Only a converter sitting in IDLE may accept a new value.
  assign conv_start = (value_reg != last_conv_reg) && !conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (value_reg),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg     <= '0;
      last_conv_reg <= '0;
      disp_reg      <= '0;
    end else begin
      value_reg <= value;
      if (conv_start) last_conv_reg <= value_reg;
      if (conv_done)  disp_reg      <= conv_bcd;
    end
  end

  logic [2:0] slot_blank;
  logic [6:0] slot_seg [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    assign slot_seg[gi] = seg_of(disp_reg[4*gi +: 4]);
  end

  assign slot_blank[UNITS]    = 1'b0;
  assign slot_blank[TENS]     = (BLANK_LZ != 0) && (disp_reg[11:4] == 8'd0);
  assign slot_blank[HUNDREDS] = (BLANK_LZ != 0) && (disp_reg[11:8] == 4'd0);

  // Active-high slot content; polarity is applied when registering.
  always_comb begin
    seg_next = 7'h00;
    dig_next = 3'b000;
    case (scan_idx_reg)
      UNITS: begin
        seg_next = slot_seg[0];
        dig_next = 3'b001;
      end
      TENS: begin
        if (!slot_blank[TENS]) begin
          seg_next = slot_seg[1];
          dig_next = 3'b010;
        end
      end
      HUNDREDS: begin
        if (!slot_blank[HUNDREDS]) begin
          seg_next = slot_seg[2];
          dig_next = 3'b100;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_reg <= '0;
      scan_idx_reg <= UNITS;
      seg_reg      <= SEG_OFF;
      dig_reg      <= DIG_OFF;
    end else begin
      if (prescale_reg == PRE_MAX) begin
        prescale_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == HUNDREDS) ? UNITS : scan_idx_reg + 2'd1;
      end else begin
        prescale_reg <= prescale_reg + 1'b1;
      end
      seg_reg <= seg_next ^ SEG_OFF;
      dig_reg <= dig_next ^ DIG_OFF;
    end
  end

  assign seg      = seg_reg;
  assign digit_en = dig_reg;
  assign dp       = (SEG_ACTIVE_LOW != 0);
  assign busy     = conv_busy;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: default build plus a no-blanking
// build, checked against a decimal-arithmetic model of the display.
module tb_count_display_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;
  logic [2:0] dig, dig_nb;
  logic       busy, busy_nb;

  always #5 clk = ~clk;

  count_display_driver #(.CLK_FREQ(1000), .SCAN_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .value(value),
    .seg(seg), .dp(dp), .digit_en(dig), .busy(busy)
  );

  count_display_driver #(.CLK_FREQ(1000), .SCAN_HZ(100), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .value(value),
    .seg(seg_nb), .dp(dp_nb), .digit_en(dig_nb), .busy(busy_nb)
  );

  typedef struct {
    int val;
    int end_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   shown = 0;
  int   busy_len = 0;
  bit   prev_busy = 1'b0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int digit_at(int v, int slot);
    if (slot == 0) return v % 10;
    if (slot == 1) return (v / 10) % 10;
    return v / 100;
  endfunction

  function automatic bit is_blank(int v, int slot, bit lz);
    if (!lz) return 1'b0;
    if (slot == 2) return v < 100;
    if (slot == 1) return v < 10;
    return 1'b0;
  endfunction

  function automatic logic [6:0] exp_seg(int v, int slot, bit lz);
    if (is_blank(v, slot, lz)) return 7'h7F;
    return ~pat[digit_at(v, slot)];
  endfunction

  function automatic logic [2:0] exp_dig(int v, int slot, bit lz);
    if (is_blank(v, slot, lz)) return 3'b111;
    return ~(3'b001 << slot);
  endfunction

  // Monitor: scan outputs every cycle, conversion results on each busy fall.
  always begin
    int slot;
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      cyc = 0; prev_busy = 1'b0; busy_len = 0; shown = 0;
    end else begin
      cyc++;
      slot = ((cyc - 1) / 10) % 3;
      total++;
      if (seg !== exp_seg(shown, slot, 1'b1) || dig !== exp_dig(shown, slot, 1'b1) || dp !== 1'b1 ||
          seg_nb !== exp_seg(shown, slot, 1'b0) || dig_nb !== exp_dig(shown, slot, 1'b0) || dp_nb !== 1'b1) begin
        bad++;
        $display("FAIL scan cyc=%0d slot=%0d shown=%0d: got seg=%h/%h dig=%b/%b dp=%b/%b, want seg=%h/%h dig=%b/%b dp=1/1",
                 cyc, slot, shown, seg, seg_nb, dig, dig_nb, dp, dp_nb,
                 exp_seg(shown, slot, 1'b1), exp_seg(shown, slot, 1'b0),
                 exp_dig(shown, slot, 1'b1), exp_dig(shown, slot, 1'b0));
      end
      if (busy) begin
        busy_len++;
      end else if (prev_busy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_conv cyc=%0d: got a conversion, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (busy_len != 9 || (e.end_cyc >= 0 && cyc != e.end_cyc)) begin
            bad++;
            $display("FAIL conv val=%0d: got end=%0d busy_len=%0d, want end=%0d busy_len=9",
                     e.val, cyc, busy_len, e.end_cyc);
          end
          shown = e.val;
        end
        busy_len = 0;
      end
      prev_busy = busy;
      if (busy !== busy_nb) begin
        total++; bad++;
        $display("FAIL busy_match cyc=%0d: got %b, want %b", cyc, busy_nb, busy);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(int v, bit expect_conv);
    value = v[7:0];
    if (expect_conv) exp_q.push_back('{v, cyc + 11});
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      tick(1);
      k++;
    end
    total++;
    if (k >= 200) begin
      bad++;
      $display("FAIL idle_timeout: got pending=%0d busy=%b, want pending=0 busy=0", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  initial begin
    int c0;
    int v;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;

    // Idle after reset: no conversion for value 0
    for (int i = 0; i < 35; i++) begin
      tick(1);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_busy cyc=%0d: got %b, want 0", cyc, busy);
      end
    end

    drive(255, 1'b1); wait_idle(); tick(35);
    drive(7, 1'b1);   wait_idle(); tick(35);

    // Change arriving while the first conversion runs is picked up afterwards
    c0 = cyc + 1;
    drive(100, 1'b1);
    tick(2);
    value = 8'd101;
    exp_q.push_back('{101, c0 + 20});
    wait_idle(); tick(35);

    drive(9, 1'b1); wait_idle(); tick(5);
    c0 = cyc + 1;
    drive(10, 1'b1);
    tick(2);
    value = 8'd9;
    exp_q.push_back('{9, c0 + 20});
    wait_idle(); tick(5);

    // Excursion that reverts before the converter is idle again: one conversion only
    drive(10, 1'b1);
    tick(2); value = 8'd11;
    tick(2); value = 8'd10;
    wait_idle(); tick(35);

    // Reset in the middle of a conversion
    drive(200, 1'b1);
    tick(4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (seg !== 7'h7F || dp !== 1'b1 || dig !== 3'b111 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got seg=%h dp=%b dig=%b busy=%b, want seg=7f dp=1 dig=111 busy=0",
               seg, dp, dig, busy);
    end
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    exp_q.push_back('{200, 11});
    tick(1);
    wait_idle(); tick(35);

    for (int i = 0; i < 25; i++) begin
      do v = int'($urandom_range(0, 255)); while (v == int'(value));
      drive(v, 1'b1);
      tick(int'($urandom_range(12, 40)));
    end
    wait_idle(); tick(35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
